display_arbiter: RTL and testbench
==================================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter: HOLD_CYCLES, default 50_000_000, minimum cycles a message or error stays on the display once shown.
REQ-002 Parameter: BLINK_DIV, default 12_500_000, error blink half-period in cycles (used only with DISPLAY_BLINK_EN).
REQ-003 Port: clk  in  1  single system clock; all state SHALL change on its rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-005 Port: base_digits  in  16  default digits {d3,d2,d1,d0}, sampled every cycle.
REQ-006 Port: msg_req  in  1 / msg_digits  in  16 / msg_ack  out  1  message request handshake.
REQ-007 Port: err_req  in  1 / err_code  in  4  error request, level-sensitive, with code.
REQ-008 Port: num0..num3  out  4 each / error  out  4  registered digit and error feed to the seven-segment driver.
REQ-009 Port: owner  out  2  current display owner: 0=BASE, 1=MSG, 2=ERR.

Function
REQ-010 The FSM SHALL have exactly three states: BASE, MSG and ERR; owner SHALL equal the state encoding.
REQ-011 In BASE, num0..num3 SHALL follow base_digits with one cycle of latency, and error SHALL be 0.
REQ-012 A valid error request is err_req=1 with err_code!=0; err_req with err_code=0 SHALL be ignored.
REQ-013 A valid error request SHALL move the FSM to ERR from any state on the next edge, latch err_code, and load the hold counter with HOLD_CYCLES-1.
REQ-014 In ERR, error SHALL equal the latched code, and num outputs SHALL hold their values from entry.
REQ-015 ERR SHALL exit to BASE only when the hold counter is 0 and no valid error request is present; a new valid request in ERR SHALL relatch the code and reload the counter.
REQ-016 In BASE with no valid error request, msg_req=1 SHALL cause entry to MSG, latch msg_digits, pulse msg_ack high for exactly one cycle, and load the hold counter.
REQ-017 In MSG, num0..num3 SHALL show the latched message; exit to BASE SHALL occur when the counter reaches 0.
REQ-018 A message preempted by ERR SHALL be dropped, not resumed; it SHALL already have been acked.
REQ-019 msg_req SHALL NOT be acked while in MSG or ERR; the requester holds msg_req until msg_ack.
REQ-020 If valid err and msg_req are asserted in the same cycle, ERR SHALL win and msg_ack SHALL stay 0.
REQ-021 The hold counter SHALL saturate at 0 and SHALL be sized $clog2(HOLD_CYCLES) bits minimum.

Reset
REQ-022 rst_n=0 SHALL immediately force BASE, owner=0, num0..num3=0, error=0, msg_ack=0, and clear all counters and latches.
REQ-023 Reset asserted mid-MSG or mid-ERR SHALL discard the latched content; after release, the first edge SHALL follow REQ-011/013/016.

Configuration
REQ-024 With DISPLAY_BLINK_EN defined, in ERR the error output SHALL alternate between the latched code and 0 every BLINK_DIV cycles, starting with the code on entry; num outputs SHALL show base_digits during the 0 phase.
REQ-025 Without DISPLAY_BLINK_EN, error SHALL be constant in ERR, and no blink counter SHALL be instantiated.

Structure
REQ-026 A shared package SHALL hold the owner state enum (BASE/MSG/ERR) and the NO_ERROR=4'd0 constant.
REQ-027 A single sub-module, hold_timer (load, count-down, zero flag), SHALL be instantiated for the hold counter and reused for the blink counter.

Verification
REQ-028 Reset release with base_digits=16'h1234 -> after 1 edge, num3..num0=1,2,3,4; owner=0; error=0.
REQ-029 HOLD_CYCLES=10, msg_req with msg_digits=16'hABCD in BASE -> msg_ack is a 1-cycle pulse, digits show A,B,C,D for 10 cycles, then base.
REQ-030 err_req=1 with err_code=3 during MSG -> next edge owner=2, error=3; after err_req drops, display returns to BASE after 10 cycles; message is not resumed.
REQ-031 err_req and msg_req asserted in the same cycle -> ERR entered and msg_ack=0; err_req=1 with err_code=0 -> no state change.
REQ-032 rst_n pulsed low mid-ERR -> outputs are 0 asynchronously; after release, BASE is shown.
REQ-033 DISPLAY_BLINK_EN, BLINK_DIV=4, err_code=5 -> error sequence is 5,5,5,5,0,0,0,0,5... while held.

Source files
------------

// File: rtl/display_arbiter_pkg.sv
// Shared types and constants for the display arbiter: owner encoding,
// the "no error" code and a counter-width helper.
package display_arbiter_pkg;

    typedef enum logic [1:0] {
        BASE = 2'd0,
        MSG  = 2'd1,
        ERR  = 2'd2
    } owner_e;

    localparam logic [3:0] NO_ERROR = 4'd0;

    // Width needed for a down-counter that is loaded with cycles-1; never below 1 bit.
    function automatic int timer_width(input int cycles);
        return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/display_arbiter_hold_timer.sv
// Loadable down-counter that saturates at zero and flags terminal count.
// Used for the display hold time and, when enabled, the error blink period.
module hold_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates the seven-segment display between base digits, acked messages and
// level-sensitive error codes. Define DISPLAY_BLINK_EN to blink the error code.
//
// state | meaning
// BASE  | show base_digits (one cycle latency), error = 0
// MSG   | show latched message until the hold timer expires
// ERR   | show latched error code, digits frozen from entry
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int BLINK_DIV   = 12_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] base_digits,
    input  logic        msg_req,
    input  logic [15:0] msg_digits,
    output logic        msg_ack,
    input  logic        err_req,
    input  logic [3:0]  err_code,
    output logic [3:0]  num0,
    output logic [3:0]  num1,
    output logic [3:0]  num2,
    output logic [3:0]  num3,
    output logic [3:0]  error,
    output logic [1:0]  owner
);

    localparam int HW = timer_width(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    owner_e      state, state_nxt;
    logic [15:0] disp, disp_sel, disp_nxt;
    logic [15:0] msg_q, msg_nxt;
    logic [3:0]  code_q, code_nxt;
    logic [3:0]  error_q, error_nxt;
    logic        ack_q, ack_nxt;
    logic        hold_load, hold_dec, hold_zero;
    logic        err_valid;

    assign err_valid = err_req && (err_code != NO_ERROR);

    hold_timer #(.WIDTH(HW)) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_load),
        .dec      (hold_dec),
        .load_val (HOLD_LOAD),
        .zero     (hold_zero)
    );

    // A valid error overrides everything, including a same-cycle message request.
    always_comb begin
        state_nxt = state;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        ack_nxt   = 1'b0;
        msg_nxt   = msg_q;
        code_nxt  = code_q;
        disp_sel  = disp;
        if (err_valid) begin
            state_nxt = ERR;
            code_nxt  = err_code;
            hold_load = 1'b1;
            msg_nxt   = '0;
        end else begin
            case (state)
                BASE: begin
                    if (msg_req) begin
                        state_nxt = MSG;
                        msg_nxt   = msg_digits;
                        ack_nxt   = 1'b1;
                        hold_load = 1'b1;
                        disp_sel  = msg_digits;
                    end else begin
                        disp_sel = base_digits;
                    end
                end
                MSG: begin
                    if (hold_zero) begin
                        state_nxt = BASE;
                        disp_sel  = base_digits;
                        msg_nxt   = '0;
                    end else begin
                        hold_dec = 1'b1;
                        disp_sel = msg_q;
                    end
                end
                ERR: begin
                    if (hold_zero) begin
                        state_nxt = BASE;
                        disp_sel  = base_digits;
                        code_nxt  = NO_ERROR;
                    end else begin
                        hold_dec = 1'b1;
                    end
                end
                default: begin
                    state_nxt = BASE;
                    disp_sel  = base_digits;
                end
            endcase
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int BW = timer_width(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_DIV - 1);

    logic        blink_on, blink_on_nxt;
    logic        blink_load, blink_dec, blink_zero;
    logic        err_entry, err_stay;
    logic [15:0] disp_entry;

    assign err_entry = (state_nxt == ERR) && (state != ERR);
    assign err_stay  = (state_nxt == ERR) && (state == ERR);

    hold_timer #(.WIDTH(BW)) u_blink (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (blink_load),
        .dec      (blink_dec),
        .load_val (BLINK_LOAD),
        .zero     (blink_zero)
    );

    // Blink phase runs freely across code relatches; only a fresh entry restarts it.
    always_comb begin
        blink_on_nxt = blink_on;
        blink_load   = 1'b0;
        blink_dec    = 1'b0;
        if (err_entry) begin
            blink_on_nxt = 1'b1;
            blink_load   = 1'b1;
        end else if (err_stay) begin
            if (blink_zero) begin
                blink_on_nxt = ~blink_on;
                blink_load   = 1'b1;
            end else begin
                blink_dec = 1'b1;
            end
        end
        error_nxt = ((state_nxt == ERR) && blink_on_nxt) ? code_nxt : NO_ERROR;
        disp_nxt  = disp_sel;
        if (err_stay) begin
            disp_nxt = blink_on_nxt ? disp_entry : base_digits;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_on   <= 1'b0;
            disp_entry <= '0;
        end else begin
            blink_on <= blink_on_nxt;
            if (err_entry) begin
                disp_entry <= disp;
            end
        end
    end
`else
    always_comb begin
        error_nxt = (state_nxt == ERR) ? code_nxt : NO_ERROR;
        disp_nxt  = disp_sel;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BASE;
            disp    <= '0;
            msg_q   <= '0;
            code_q  <= NO_ERROR;
            error_q <= NO_ERROR;
            ack_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            disp    <= disp_nxt;
            msg_q   <= msg_nxt;
            code_q  <= code_nxt;
            error_q <= error_nxt;
            ack_q   <= ack_nxt;
        end
    end

    assign num0    = disp[3:0];
    assign num1    = disp[7:4];
    assign num2    = disp[11:8];
    assign num3    = disp[15:12];
    assign error   = error_q;
    assign msg_ack = ack_q;
    assign owner   = state;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed scenarios plus random
// stimulus, all compared against a behavioural display model.
module tb_display_arbiter;

    localparam int HOLD = 10;
    localparam int BDIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] base_digits;
    logic        msg_req;
    logic [15:0] msg_digits;
    logic        msg_ack;
    logic        err_req;
    logic [3:0]  err_code;
    logic [3:0]  num0, num1, num2, num3, error;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_errors = 0;

    // Model: who owns the display, what is shown, how many visible cycles remain.
    int          m_owner;
    int          m_left;
    int          m_t;
    logic [15:0] m_disp;
    logic [15:0] m_entry;
    logic [3:0]  m_code;
    logic [3:0]  m_err;
    logic        m_ack;

    display_arbiter #(.HOLD_CYCLES(HOLD), .BLINK_DIV(BDIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .base_digits (base_digits),
        .msg_req     (msg_req),
        .msg_digits  (msg_digits),
        .msg_ack     (msg_ack),
        .err_req     (err_req),
        .err_code    (err_code),
        .num0        (num0),
        .num1        (num1),
        .num2        (num2),
        .num3        (num3),
        .error       (error),
        .owner       (owner)
    );

    always #5 clk = ~clk;

    logic [22:0] act;
    assign act = {owner, num3, num2, num1, num0, error, msg_ack};

    function automatic logic [22:0] m_vec();
        return {m_owner[1:0], m_disp, m_err, m_ack};
    endfunction

    task automatic model_reset();
        m_owner = 0; m_left = 0; m_t = 0;
        m_disp = '0; m_entry = '0; m_code = '0; m_err = '0; m_ack = 1'b0;
    endtask

    task automatic model_edge();
        logic ev;
        ev = err_req && (err_code != 4'd0);
        m_ack = 1'b0;
        if (ev) begin
            if (m_owner != 2) begin
                m_t = 0;
                m_entry = m_disp;
            end else begin
                m_t++;
            end
            m_owner = 2;
            m_code  = err_code;
            m_left  = HOLD;
        end else if (m_owner == 0) begin
            if (msg_req) begin
                m_owner = 1;
                m_disp  = msg_digits;
                m_ack   = 1'b1;
                m_left  = HOLD;
            end else begin
                m_disp = base_digits;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_owner = 0;
                m_disp  = base_digits;
                m_code  = 4'd0;
            end else if (m_owner == 2) begin
                m_t++;
            end
        end
        m_err = (m_owner == 2) ? m_code : 4'd0;
`ifdef DISPLAY_BLINK_EN
        if (m_owner == 2) begin
            if (((m_t / BDIV) % 2) == 1) begin
                m_err  = 4'd0;
                m_disp = base_digits;
            end else begin
                m_disp = m_entry;
            end
        end
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; base_digits = 16'h1234; msg_req = 1'b0; msg_digits = '0;
        err_req = 1'b0; err_code = '0;
        model_reset();
        #12;
        n_checks++;
        if (act !== 23'd0) begin
            n_errors++;
            $display("FAIL reset_hold got=%h exp=%h", act, 23'd0);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({owner, num3, num2, num1, num0, error} !== {2'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}) begin
            n_errors++;
            $display("FAIL reset_release got=%h exp=%h", act, m_vec());
        end
    endtask

    task automatic test_msg();
        msg_req = 1'b1; msg_digits = 16'hABCD; base_digits = 16'h5678;
        tick();
        msg_req = 1'b0; msg_digits = 16'h0000;
        n_checks++;
        if (msg_ack !== 1'b1 || {num3, num2, num1, num0} !== 16'hABCD || owner !== 2'd1) begin
            n_errors++;
            $display("FAIL msg_entry got=%h exp=%h", act, m_vec());
        end
        for (int i = 0; i < HOLD + 2; i++) begin
            tick();
            n_checks++;
            if (act !== m_vec()) begin
                n_errors++;
                $display("FAIL msg_hold cyc=%0d got=%h exp=%h", i, act, m_vec());
            end
        end
        n_checks++;
        if (owner !== 2'd0 || {num3, num2, num1, num0} !== 16'h5678) begin
            n_errors++;
            $display("FAIL msg_exit got=%h exp owner=0 digits=5678", act);
        end
    endtask

    task automatic test_err_preempt();
        msg_req = 1'b1; msg_digits = 16'h9876;
        tick();
        msg_req = 1'b0;
        tick();
        tick();
        err_req = 1'b1; err_code = 4'd3;
        tick();
        n_checks++;
        if (owner !== 2'd2 || error !== 4'd3) begin
            n_errors++;
            $display("FAIL err_preempt got=%h exp=%h", act, m_vec());
        end
        tick();
        err_req = 1'b0; err_code = 4'd0; base_digits = 16'h4321;
        for (int i = 0; i < HOLD + 3; i++) begin
            tick();
            n_checks++;
            if (act !== m_vec()) begin
                n_errors++;
                $display("FAIL err_hold cyc=%0d got=%h exp=%h", i, act, m_vec());
            end
        end
        n_checks++;
        if (owner !== 2'd0 || {num3, num2, num1, num0} !== 16'h4321) begin
            n_errors++;
            $display("FAIL err_no_resume got=%h exp owner=0 digits=4321", act);
        end
    endtask

    task automatic test_same_cycle();
        msg_req = 1'b1; msg_digits = 16'hBEEF; err_req = 1'b1; err_code = 4'd9;
        tick();
        err_req = 1'b0; err_code = 4'd0;
        n_checks++;
        if (owner !== 2'd2 || msg_ack !== 1'b0 || error !== 4'd9) begin
            n_errors++;
            $display("FAIL same_cycle got=%h exp=%h", act, m_vec());
        end
        for (int i = 0; i < HOLD + 2; i++) begin
            tick();
            n_checks++;
            if (act !== m_vec()) begin
                n_errors++;
                $display("FAIL same_cycle_tail cyc=%0d got=%h exp=%h", i, act, m_vec());
            end
        end
        msg_req = 1'b0;
        for (int i = 0; i < HOLD + 2; i++) tick();
        err_req = 1'b1; err_code = 4'd0; base_digits = 16'h0F0F;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (owner !== 2'd0 || error !== 4'd0 || act !== m_vec()) begin
                n_errors++;
                $display("FAIL err_code_zero cyc=%0d got=%h exp=%h", i, act, m_vec());
            end
        end
        err_req = 1'b0;
    endtask

    task automatic test_reset_mid_err();
        err_req = 1'b1; err_code = 4'd7;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (act !== 23'd0) begin
            n_errors++;
            $display("FAIL reset_async got=%h exp=%h", act, 23'd0);
        end
        err_req = 1'b0; err_code = 4'd0; base_digits = 16'h2468;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (owner !== 2'd0 || {num3, num2, num1, num0} !== 16'h2468 || act !== m_vec()) begin
            n_errors++;
            $display("FAIL reset_release_base got=%h exp=%h", act, m_vec());
        end
    endtask

`ifdef DISPLAY_BLINK_EN
    task automatic test_blink();
        err_req = 1'b1; err_code = 4'd5;
        for (int i = 0; i < 3 * BDIV + 1; i++) begin
            tick();
            n_checks++;
            if (act !== m_vec()) begin
                n_errors++;
                $display("FAIL blink cyc=%0d got=%h exp=%h", i, act, m_vec());
            end
        end
        err_req = 1'b0; err_code = 4'd0;
        for (int i = 0; i < HOLD + 2; i++) tick();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            base_digits = 16'($urandom);
            msg_digits  = 16'($urandom);
            msg_req     = ($urandom_range(0, 3) == 0);
            err_req     = ($urandom_range(0, 19) == 0);
            err_code    = 4'($urandom_range(0, 15));
            tick();
            n_checks++;
            if (act !== m_vec()) begin
                n_errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, act, m_vec());
            end
        end
        msg_req = 1'b0; err_req = 1'b0; err_code = 4'd0;
    endtask

    initial begin
        test_reset();
        test_msg();
        test_err_preempt();
        test_same_cycle();
        test_reset_mid_err();
`ifdef DISPLAY_BLINK_EN
        test_blink();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
